// File: rtl/seg_scan_mux.sv
// Multiplexed hex display scanner: frame-synchronous value buffering, dead time,
// leading-zero blanking, one-hot anode drive for a downstream 7-segment encoder.

module seg_scan_lane #(
  parameter bit BLANKABLE = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       dp_bit,
  input  logic       upper_zero,
  input  logic       sel,
  input  logic       show,
  input  logic       lz,
  output logic       an,
  output logic       lit,
  output logic       dpo
);
  logic blank;

  // A blanked digit keeps its anode so every digit sees the same duty cycle.
  assign blank = BLANKABLE && lz && upper_zero && (nib == 4'd0);
  assign an    = sel && show;
  assign lit   = an && !blank;
  assign dpo   = lit && dp_bit;
endmodule

module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic                    display_on,
  output logic [3:0]              bcd,
  output logic                    enable,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    dp,
  output logic                    frame_tick
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0]                  div_cnt;
  logic [IW-1:0]                  digit_idx;
  logic [NUM_DIGITS-1:0][3:0]     act_val, pend_val;
  logic [NUM_DIGITS-1:0]          act_dp, pend_dp;
  logic                           pend_flag;
  logic                           lz_r, on_r;
  logic                           slot_end, dead, show;
  logic [4*NUM_DIGITS-1:0]        act_flat;
  logic [NUM_DIGITS-1:0]          zabove, sel, an_h, lit_h, dpo_h;

  assign slot_end   = (div_cnt == DIV_LAST);
  assign frame_tick = slot_end && (digit_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // Active value only changes at frame boundaries; a load on the boundary itself
  // bypasses the pending register so the newest value wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val   <= '0;
      act_dp    <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else if (frame_tick) begin
      pend_flag <= 1'b0;
      if (load) begin
        act_val <= value_in;
        act_dp  <= dp_in;
      end else if (pend_flag) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
    end else if (load) begin
      pend_val  <= value_in;
      pend_dp   <= dp_in;
      pend_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_r <= 1'b0;
      on_r <= 1'b0;
    end else begin
      lz_r <= lz_blank;
      on_r <= display_on;
    end
  end

  assign dead     = (BLANK_CYCLES > 0) && (div_cnt < DW'(BLANK_CYCLES));
  assign show     = on_r && !dead;
  assign act_flat = act_val;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_lane
      if (i == NUM_DIGITS - 1) begin : g_top
        assign zabove[i] = 1'b1;
      end else begin : g_low
        assign zabove[i] = (act_flat[4*NUM_DIGITS-1:4*(i+1)] == '0);
      end
      assign sel[i] = (digit_idx == IW'(i));

      seg_scan_lane #(.BLANKABLE(i > 0)) u_lane (
        .nib        (act_val[i]),
        .dp_bit     (act_dp[i]),
        .upper_zero (zabove[i]),
        .sel        (sel[i]),
        .show       (show),
        .lz         (lz_r),
        .an         (an_h[i]),
        .lit        (lit_h[i]),
        .dpo        (dpo_h[i])
      );
    end
  endgenerate

  assign bcd    = act_val[digit_idx];
  assign enable = |lit_h;
  assign anode  = (ACTIVE_LOW != 0) ? ~an_h : an_h;
  assign dp     = (ACTIVE_LOW != 0) ? ~(|dpo_h) : (|dpo_h);
endmodule
